// File: rtl/bcd_bin_sequencer_if.sv
// Handshake bundle for the BCD-to-binary sequencer: input word channel, result channel, status.
interface bcd_bin_sequencer_if #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned OUT_W  = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      bin_out;
  logic                  err;
  logic                  busy;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err, busy
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err, busy
  );
endinterface

// File: rtl/bcd_bin_sequencer.sv
// Serial packed-BCD to binary converter: one digit per clock, MS digit first,
// with valid/ready handshakes on both sides.
module bcd_bin_sequencer #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned OUT_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_bin_sequencer_if.slave bus
);
  localparam int unsigned IN_W  = 4 * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned ACC_W = OUT_W + 4;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e             r_state;
  logic               r_rst_done;
  logic [IN_W-1:0]    r_shift;
  logic [OUT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic [3:0]         w_digit;
  logic [ACC_W-1:0]   w_acc_ext;
  logic [OUT_W-1:0]   w_acc_next;
  logic               w_bad_digit;

  assign w_digit    = r_shift[IN_W-1 -: 4];
  assign w_acc_ext  = ACC_W'(r_acc);
  // acc*10 as two shifts; legal digits never exceed OUT_W so truncation is lossless
  assign w_acc_next = OUT_W'((w_acc_ext << 3) + (w_acc_ext << 1) + ACC_W'(w_digit));

  always_comb begin
    w_bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) w_bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_rst_done <= 1'b0;
      r_shift    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      // Holds in_ready low for the reset cycle itself; set on the first released edge
      r_rst_done <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (r_rst_done && bus.in_valid) begin
            r_shift <= bus.bcd_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= w_bad_digit;
            r_state <= StConv;
          end
        end
        StConv: begin
          r_acc   <= w_acc_next;
          r_shift <= r_shift << 4;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DIGITS - 1)) r_state <= StDone;
        end
        StDone: begin
          if (bus.out_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == StIdle) && r_rst_done;
  assign bus.out_valid = (r_state == StDone);
  assign bus.busy      = (r_state == StConv);
  assign bus.err       = (r_state == StDone) && r_err;
  assign bus.bin_out   = ((r_state == StDone) && !r_err) ? r_acc : '0;
endmodule
